// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-over-PCF8574 LCD path:
//   - PCF8574 bit positions of the LCD control lines
//   - common HD44780 instruction codes
//   - sequencer state encoding
//   - lcd_frame(): builds one PCF8574 frame byte of the 4-bit write sequence
// -----------------------------------------------------------------------------
package lcd_pkg;

    // PCF8574 output bit positions; the data nibble occupies [7:4].
    localparam int LCD_BL = 3;
    localparam int LCD_EN = 2;
    localparam int LCD_RW = 1;
    localparam int LCD_RS = 0;

    // HD44780 instruction codes.
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_FUNC_4B2L = 8'h28;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_LINE1     = 8'h80;
    localparam logic [7:0] LCD_LINE2     = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLD      = 2'd3
    } lcd_state_e;

    // Frame index: bit 1 selects the nibble (0 = high, 1 = low),
    // bit 0 selects the E phase (0 = E high, 1 = E low).
    function automatic logic [7:0] lcd_frame(input logic [7:0] byte_v,
                                             input logic [1:0] idx,
                                             input logic       bl,
                                             input logic       rs);
        logic [7:0] f;
        f         = 8'h00;
        f[7:4]    = idx[1] ? byte_v[3:0] : byte_v[7:4];
        f[LCD_BL] = bl;
        f[LCD_EN] = ~idx[0];
        f[LCD_RW] = 1'b0;
        f[LCD_RS] = rs;
        return f;
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// -----------------------------------------------------------------------------
// lcd_delay_counter
// Loadable down-counter that stops at zero. tc_o is high whenever the count
// is zero, so a load of 0 yields terminal count on the very next cycle.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   load_i     in   load strobe (takes priority over counting)
//   load_val_i in   value loaded on load_i
//   tc_o       out  terminal count (count == 0)
// -----------------------------------------------------------------------------
module lcd_delay_counter #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_nibble_sequencer
// Turns one LCD instruction/data byte into the PCF8574 frame sequence for an
// HD44780 in 4-bit mode (high nibble with E pulse, then low nibble with E
// pulse), issuing each frame as a single-byte i2c_master write, then holds
// off for the controller's execution delay.
//
// Optional feature macro: LCD_LONG_CMD_DELAY_EN
//   defined   : Clear (0x01) / Return Home (0x02) instructions wait LONG_WAIT_CYC
//   undefined : every transfer waits SHORT_WAIT_CYC (upstream handles 2 ms)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream byte handshake (accept = in_valid && in_ready)
//   in_byte         instruction or character code
//   in_rs           0 = instruction, 1 = data
//   in_nibble_only  send the high nibble only
//   backlight       BL bit for this transfer
//   i2c_start       one-cycle start pulse to i2c_master
//   i2c_data        PCF8574 byte to write
//   i2c_busy        master transfer in progress
//   i2c_done        master completion pulse
//   busy            high from accept until in_ready returns
// -----------------------------------------------------------------------------
module lcd_nibble_sequencer
    import lcd_pkg::*;
#(
    parameter int SHORT_WAIT_CYC = 5000,
    parameter int LONG_WAIT_CYC  = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_rs,
    input  logic       in_nibble_only,
    input  logic       backlight,
    output logic       i2c_start,
    output logic [7:0] i2c_data,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    output logic       busy
);

    localparam int CNT_W = $clog2(LONG_WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_WAIT_CYC);

    lcd_state_e state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic [7:0] byte_q,  byte_d;
    logic       rs_q,    rs_d;
    logic       nib_q,   nib_d;
    logic       bl_q,    bl_d;
    logic [7:0] data_q,  data_d;

    logic             cnt_load;
    logic             cnt_tc;
    logic [CNT_W-1:0] wait_val;
    logic             last_frame;

    // Nibble-only transfers end after F1, full bytes after F3.
    assign last_frame = nib_q ? (idx_q == 2'd1) : (idx_q == 2'd3);

`ifdef LCD_LONG_CMD_DELAY_EN
    localparam logic [CNT_W-1:0] LONG_LD = CNT_W'(LONG_WAIT_CYC);
    logic long_sel;
    assign long_sel = !rs_q && ((byte_q == LCD_CLEAR) || (byte_q == LCD_HOME));
    assign wait_val = long_sel ? LONG_LD : SHORT_LD;
`else
    assign wait_val = SHORT_LD;
`endif

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        rs_d      = rs_q;
        nib_d     = nib_q;
        bl_d      = bl_q;
        data_d    = data_q;
        cnt_load  = 1'b0;
        i2c_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    byte_d  = in_byte;
                    rs_d    = in_rs;
                    nib_d   = in_nibble_only;
                    bl_d    = backlight;
                    idx_d   = 2'd0;
                    // F0 is registered at accept so it is already on
                    // i2c_data in the first ISSUE cycle.
                    data_d  = lcd_frame(in_byte, 2'd0, backlight, in_rs);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i2c_busy) begin
                    i2c_start = 1'b1;
                    state_d   = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_done) begin
                    if (last_frame) begin
                        cnt_load = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        data_d  = lcd_frame(byte_q, idx_q + 2'd1, bl_q, rs_q);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                // Counter holds N right after the load, so HOLD spans N+1 cycles.
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            byte_q  <= 8'h00;
            rs_q    <= 1'b0;
            nib_q   <= 1'b0;
            bl_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            nib_q   <= nib_d;
            bl_q    <= bl_d;
            data_q  <= data_d;
        end
    end

    lcd_delay_counter #(
        .WIDTH (CNT_W)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (wait_val),
        .tc_o       (cnt_tc)
    );

    assign i2c_data = data_q;
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_nibble_sequencer
// Self-checking bench: a byte-level model (expected frame list per accepted
// byte, expected ready cycle after the final completion) is compared against
// the DUT every cycle, alongside directed checks with hand-computed frames.
// Follows LCD_LONG_CMD_DELAY_EN for the expected Clear/Home wait.
// -----------------------------------------------------------------------------
module tb_lcd_nibble_sequencer;

    localparam int SHORT = 6;
    localparam int LONG  = 31;
`ifdef LCD_LONG_CMD_DELAY_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'h00;
    logic       in_rs = 1'b0;
    logic       in_nibble_only = 1'b0;
    logic       backlight = 1'b0;
    logic       i2c_start;
    logic [7:0] i2c_data;
    logic       i2c_busy;
    logic       i2c_done;
    logic       busy;

    logic m_busy = 1'b0, m_done = 1'b0, ext_busy = 1'b0, spur_done = 1'b0;
    assign i2c_busy = m_busy | ext_busy;
    assign i2c_done = m_done | spur_done;

    lcd_nibble_sequencer #(
        .SHORT_WAIT_CYC (SHORT),
        .LONG_WAIT_CYC  (LONG)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_byte        (in_byte),
        .in_rs          (in_rs),
        .in_nibble_only (in_nibble_only),
        .backlight      (backlight),
        .i2c_start      (i2c_start),
        .i2c_data       (i2c_data),
        .i2c_busy       (i2c_busy),
        .i2c_done       (i2c_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- i2c_master stand-in: busy 1..4 cycles, then done ----
    initial begin
        int  m_cnt;
        logic st, rs_s;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            st   = i2c_start;
            rs_s = rst;
            @(posedge clk);
            #1;
            m_done = 1'b0;
            if (rs_s || rst) begin
                m_cnt  = 0;
                m_busy = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (st) begin
                m_busy = 1'b1;
                m_cnt  = $urandom_range(1, 4);
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ---------------
    int         cyc = 0;
    bit         active = 0;
    bit         outstanding = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur = 8'h00;
    int         cur_wait = 0;
    int         ready_cyc = -1;
    int         last_done_cyc = 0;
    int         hold_diff = -1;
    bit         prev_ready = 1;
    logic [7:0] obs[$];
    int         first_start_cyc = -1;
    int         accept_cyc = 0;

    function automatic logic [7:0] mk_frame(input logic [3:0] nib, input logic bl,
                                            input logic e, input logic rs);
        return {nib, bl, e, 1'b0, rs};
    endfunction

    always @(negedge clk) begin
        bit exp_start, new_start;
        cyc++;
        new_start = 0;
        if (rst) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_i2c_start", i2c_start, 0);
            check("rst_i2c_data", i2c_data, 8'h00);
            active = 0;
            outstanding = 0;
            exp_q.delete();
            ready_cyc = -1;
            prev_ready = 1;
        end else begin
            if (active && !outstanding && exp_q.size() == 0 && cyc == ready_cyc) active = 0;
            check("in_ready", in_ready, !active);
            check("busy", busy, active);
            exp_start = active && !outstanding && (exp_q.size() != 0) && !i2c_busy;
            check("i2c_start", i2c_start, exp_start);
            if (i2c_start && exp_start) begin
                check("start_frame", i2c_data, exp_q[0]);
                cur = exp_q.pop_front();
                obs.push_back(i2c_data);
                if (first_start_cyc < 0) first_start_cyc = cyc;
                outstanding = 1;
                new_start = 1;
            end else if (outstanding) begin
                check("data_stable", i2c_data, cur);
            end
            if (i2c_done && outstanding && !new_start) begin
                outstanding = 0;
                if (exp_q.size() == 0) begin
                    ready_cyc = cyc + cur_wait + 2;
                    last_done_cyc = cyc;
                end
            end
            if (in_ready && !prev_ready) hold_diff = cyc - last_done_cyc - 1;
            prev_ready = in_ready;
            if (in_valid && !active) begin
                active = 1;
                ready_cyc = -1;
                exp_q.push_back(mk_frame(in_byte[7:4], backlight, 1'b1, in_rs));
                exp_q.push_back(mk_frame(in_byte[7:4], backlight, 1'b0, in_rs));
                if (!in_nibble_only) begin
                    exp_q.push_back(mk_frame(in_byte[3:0], backlight, 1'b1, in_rs));
                    exp_q.push_back(mk_frame(in_byte[3:0], backlight, 1'b0, in_rs));
                end
                cur_wait = (LONG_EN && !in_rs && (in_byte == 8'h01 || in_byte == 8'h02)) ? LONG : SHORT;
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic send(input logic [7:0] b, input logic rs_v, input logic nib, input logic bl);
        bit ok = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_byte = b;
        in_rs = rs_v;
        in_nibble_only = nib;
        backlight = bl;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #2;
            if (in_ready) begin
                ok = 1;
                accept_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte = 8'($urandom);
        in_rs = 1'($urandom);
        in_nibble_only = 1'($urandom);
        backlight = 1'($urandom);
        check("accept_in_time", ok, 1);
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #2;
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("ready_in_time", ok, 1);
    endtask

    task automatic run_frames(input string name, input logic [7:0] b, input logic rs_v,
                              input logic nib, input logic bl,
                              input logic [7:0] f0, input logic [7:0] f1,
                              input logic [7:0] f2, input logic [7:0] f3,
                              input int exp_hold);
        logic [7:0] ef[4];
        int n;
        ef[0] = f0; ef[1] = f1; ef[2] = f2; ef[3] = f3;
        n = nib ? 2 : 4;
        obs.delete();
        first_start_cyc = -1;
        send(b, rs_v, nib, bl);
        wait_ready();
        check({name, "_nframes"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++)
            check($sformatf("%s_f%0d", name, i), obs[i], ef[i]);
        check({name, "_hold"}, hold_diff, exp_hold + 1);
    endtask

    // ---------------- main sequence ---------------------------------------
    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_start", i2c_start, 0);
        check("reset_data", i2c_data, 8'h00);

        run_frames("func4b", 8'h28, 1'b0, 1'b0, 1'b1, 8'h2C, 8'h28, 8'h8C, 8'h88, SHORT);
        check("first_start_latency", first_start_cyc - accept_cyc, 1);
        run_frames("data_H", 8'h48, 1'b1, 1'b0, 1'b1, 8'h4D, 8'h49, 8'h8D, 8'h89, SHORT);
        run_frames("wake30", 8'h30, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h38, 8'h00, 8'h00, SHORT);
        run_frames("clear", 8'h01, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h14, 8'h10,
                   LONG_EN ? LONG : SHORT);
        run_frames("home", 8'h02, 1'b0, 1'b0, 1'b1, 8'h0C, 8'h08, 8'h2C, 8'h28,
                   LONG_EN ? LONG : SHORT);
        run_frames("data01", 8'h01, 1'b1, 1'b0, 1'b1, 8'h0D, 8'h09, 8'h1D, 8'h19, SHORT);

        // i2c_busy held for 300 cycles after accept
        obs.delete();
        first_start_cyc = -1;
        ext_busy = 1'b1;
        send(8'h0C, 1'b0, 1'b0, 1'b1);
        repeat (300) @(posedge clk);
        #1 ext_busy = 1'b0;
        wait_ready();
        check("busy_hold_start", first_start_cyc - accept_cyc, 301);

        // spurious done while in HOLD
        obs.delete();
        send(8'h06, 1'b0, 1'b0, 1'b1);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if (active && exp_q.size() == 0 && !outstanding) begin
                ok = 1;
                break;
            end
        end
        check("reached_hold", ok, 1);
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        wait_ready();
        check("spurious_done_hold", hold_diff, SHORT + 1);
        check("spurious_done_nframes", obs.size(), 4);

        // randomized back-to-back stream
        for (int k = 0; k < 40; k++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 5);
            b = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            send(b, 1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
        end
        wait_ready();

        // reset during F2, then restart from F0
        obs.delete();
        send(8'h80, 1'b0, 1'b0, 1'b1);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #2;
            if (obs.size() == 3) begin
                ok = 1;
                break;
            end
        end
        check("reached_f2", ok, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_start", i2c_start, 0);
        check("midrst_data", i2c_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_frames("after_rst", 8'hC0, 1'b0, 1'b0, 1'b1, 8'hCC, 8'hC8, 8'h0C, 8'h08, SHORT);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_nibble_sequencer.md
# lcd_nibble_sequencer

Converts one LCD command or data byte into the PCF8574 frame sequence that drives an HD44780 in 4-bit mode: high nibble with E pulsed, then low nibble with E pulsed. It then enforces the controller's post-instruction execution delay. It sits between the LCD init/text state machine (upstream, valid/ready byte interface) and `i2c_master` (downstream, start/busy/done single-byte writes). It replaces inline task-based sequencing with a synthesizable FSM.

## Interface
- `SHORT_WAIT_CYC`, default 5000: clk cycles waited after a normal instruction or data write (50 µs at 100 MHz).
- `LONG_WAIT_CYC`, default 200000: clk cycles waited after Clear (0x01) or Return Home (0x02) (2 ms).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream byte available.
- `in_ready`  out  1  block can accept a byte.
- `in_byte`  in  8  LCD instruction or character code.
- `in_rs`  in  1  0 = instruction, 1 = data.
- `in_nibble_only`  in  1  send the high nibble only (init wake-up writes 0x3_, 0x2_).
- `backlight`  in  1  BL bit value for this transfer.
- `i2c_start`  out  1  one-cycle start pulse to `i2c_master`.
- `i2c_data`  out  8  PCF8574 byte to write.
- `i2c_busy`  in  1  master transfer in progress.
- `i2c_done`  in  1  one-cycle pulse at master STOP completion.
- `busy`  out  1  high from accept until `in_ready` returns.

## Operation
- Frame byte format: [7:4] nibble, [3] BL, [2] E, [1] RW = 0, [0] RS.
- Accept occurs when `in_valid && in_ready`. On accept, capture `in_byte`, `in_rs`, `in_nibble_only` and `backlight`. Inputs are ignored at all other times.
- Frame order:
  - F0 = {hi, BL, 1, 0, RS}
  - F1 = {hi, BL, 0, 0, RS}
  - F2 = {lo, BL, 1, 0, RS}
  - F3 = {lo, BL, 0, 0, RS}
  - With nibble_only set, only F0 and F1 are sent.
- States:
  - IDLE: `in_ready` = 1. On accept, go to ISSUE with frame index 0.
  - ISSUE: drive `i2c_data` = current frame. When `i2c_busy` = 0, pulse `i2c_start` for one cycle and go to WAIT_DONE.
  - WAIT_DONE: on `i2c_done`:
    - If this is the last frame, go to HOLD and load the delay counter.
    - Otherwise increment the frame index and go to ISSUE.
  - HOLD: count down. At terminal count, go to IDLE.
- Delay selection:
  - LONG_WAIT_CYC when RS = 0 and byte ∈ {0x01, 0x02}, subject to Configuration.
  - Otherwise SHORT_WAIT_CYC.
- `i2c_data` holds its value from the start pulse until the matching `i2c_done`.
- An `i2c_done` pulse outside WAIT_DONE is ignored.
- Frame index is 2 bits. Delay counter width is $clog2(LONG_WAIT_CYC+1). A count of 0 means HOLD lasts exactly 1 cycle.

## Timing
- Reset values:
  - `in_ready` = 1 (IDLE)
  - `busy` = 0
  - `i2c_start` = 0
  - `i2c_data` = 8'h00
  - counters = 0
- Accept at edge T: `in_ready` = 0 and `busy` = 1 from T+1. The earliest `i2c_start` pulse is at cycle T+1.
- `i2c_start` is never asserted while `i2c_busy` = 1. It is never asserted twice without an intervening `i2c_done`.
- After the last `i2c_done` at edge D, `in_ready` rises at D + N + 1, where N is the selected wait.
- Back-to-back bytes: the next accept can occur on the first cycle `in_ready` = 1.
- Reset mid-transfer: the FSM is forced to IDLE and `i2c_start` drops immediately. No partial frame is resumed. The master is reset by the same `rst`.

## Configuration
- `LCD_LONG_CMD_DELAY_EN` defined: Clear and Return Home instructions use LONG_WAIT_CYC.
- Undefined: all transfers use SHORT_WAIT_CYC, and the Clear/Home decode logic is absent. Upstream must then insert its own 2 ms wait.

## Structure
- Shared package `lcd_pkg` holds:
  - bit positions LCD_BL = 3, LCD_EN = 2, LCD_RW = 1, LCD_RS = 0;
  - instruction constants LCD_CLEAR = 8'h01, LCD_HOME = 8'h02, LCD_FUNC_4B2L = 8'h28, LCD_DISP_ON = 8'h0C, LCD_ENTRY = 8'h06, LCD_LINE1 = 8'h80, LCD_LINE2 = 8'hC0;
  - the state encoding.
- One sub-module: `lcd_delay_counter` (load value, load strobe, terminal-count output).

## Test plan
- Instruction 0x28, rs = 0, bl = 1 → frames 0x2C, 0x28, 0x8C, 0x88 in order, then `in_ready` high SHORT_WAIT_CYC + 1 cycles after the 4th `i2c_done`.
- Data 0x48 ('H'), rs = 1, bl = 1 → frames 0x4D, 0x49, 0x8D, 0x89.
- nibble_only with 0x30, bl = 1 → exactly 2 frames, 0x3C then 0x38. No third start pulse.
- Instruction 0x01: with `LCD_LONG_CMD_DELAY_EN` → HOLD lasts LONG_WAIT_CYC. Without the macro → SHORT_WAIT_CYC. 0x01 with rs = 1 → SHORT in both builds.
- `i2c_busy` held high for 300 cycles after accept → no `i2c_start` until the cycle `i2c_busy` falls. Spurious `i2c_done` while in HOLD → no effect.
- `rst` asserted during F2 → `i2c_start` = 0, `i2c_data` = 0x00, `busy` = 0, `in_ready` = 1. A new byte accepted after release starts again at F0.
